// File: rtl/mux41_pkg.sv
// Shared types, sizes and the rotating-scan helper for the 4-way round-robin scheduler.
// The scan starts one past the last owner so the owner is considered last.
package mux41_pkg;

   localparam int SEL_W = 2;
   localparam int NREQ  = 4;
   localparam int CNT_W = 4;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   // First requester found scanning last+1, last+2, last+3, last (mod 4).
   function automatic logic [SEL_W-1:0] rr_pick(input logic [NREQ-1:0]  req,
                                                input logic [SEL_W-1:0] last);
      logic [SEL_W-1:0] idx;
      logic [SEL_W-1:0] win;
      logic             found;
      win   = last;
      found = 1'b0;
      for (int off = 1; off <= NREQ; off++) begin
         idx = last + SEL_W'(off);
         if (!found && req[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
      return win;
   endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotating priority encoder: the current owner keeps the slot when
// keep is set, otherwise the next requester after last wins.
module rr_pick4
   import mux41_pkg::*;
(
   input  logic [NREQ-1:0]  req,
   input  logic [SEL_W-1:0] last,
   input  logic             keep,
   output logic [SEL_W-1:0] winner,
   output logic             any
);

   always_comb begin
      winner = rr_pick(req, last);
      if (keep) begin
         winner = last;
      end
   end

   assign any = |req;

endmodule

// File: rtl/mux41_rr_sched.sv
// Round-robin scheduler sharing one 4:1 WIDTH-bit select path between four requesters,
// with a registered output beat under valid/ready and a per-owner beat quantum.
//
// Handshake: out holds a beat while out_valid=1; the beat is taken on a rising edge
// where out_valid && out_ready. A new beat may load on that same edge (slot_free),
// and gnt[i] is the only acceptance indication a requester receives.
module mux41_rr_sched
   import mux41_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int QUANTUM = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       req,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic [WIDTH-1:0] in3,
   input  logic [WIDTH-1:0] in4,
   output logic [3:0]       gnt,
   output logic [1:0]       select,
   output logic [WIDTH-1:0] out,
   output logic             out_valid,
   input  logic             out_ready,
   output state_t           state_dbg,
   output logic [CNT_W-1:0] cnt_dbg
);

   state_t             state_q;
   state_t             state_d;
   logic [CNT_W-1:0]   cnt_q;
   logic               slot_free;
   logic               keep;
   logic               any;
   logic               accept;
   logic [SEL_W-1:0]   winner;
   logic [WIDTH-1:0]   win_data;

   assign slot_free = !out_valid || out_ready;
   assign keep      = (state_q == BUSY) && req[select] && (cnt_q < CNT_W'(QUANTUM));
   assign accept    = !rst && slot_free && any;

   rr_pick4 u_pick (
      .req    (req),
      .last   (select),
      .keep   (keep),
      .winner (winner),
      .any    (any)
   );

   always_comb begin
      case (winner)
         2'd0:    win_data = in1;
         2'd1:    win_data = in2;
         2'd2:    win_data = in3;
         default: win_data = in4;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // A stall leaves the state untouched; an empty free slot drops back to IDLE.
   always_comb begin
      state_d = state_q;
      if (accept) begin
         state_d = BUSY;
      end else if (slot_free) begin
         state_d = IDLE;
      end
   end

   always_comb begin
      gnt = 4'b0000;
      if (accept) begin
         gnt[winner] = 1'b1;
      end
   end

   // A lone owner re-granted after quantum expiry is a fresh winner, so cnt restarts at 1.
   always_ff @(posedge clk) begin
      if (rst) begin
         out       <= '0;
         out_valid <= 1'b0;
         select    <= 2'b11;
         cnt_q     <= '0;
      end else if (accept) begin
         out       <= win_data;
         out_valid <= 1'b1;
         select    <= winner;
         cnt_q     <= keep ? cnt_q + 1'b1 : CNT_W'(1);
      end else if (slot_free) begin
         out_valid <= 1'b0;
         cnt_q     <= '0;
      end
   end

   assign state_dbg = state_q;
   assign cnt_dbg   = cnt_q;

endmodule

// File: tb/tb_mux41_rr_sched.sv
// Directed bench for mux41_rr_sched: one instance with QUANTUM=1 and one with QUANTUM=4
// share the stimulus; each task checks the instance its scenario targets.
module tb_mux41_rr_sched;
   import mux41_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic       out_ready;
   logic [3:0] din [4];
   logic [3:0] in1, in2, in3, in4;

   logic [3:0] gnt1, gnt4;
   logic [1:0] sel1, sel4;
   logic [3:0] out1, out4;
   logic       ov1, ov4;
   state_t     st1, st4;
   logic [3:0] cnt1, cnt4;

   int errors = 0;
   int checks = 0;

   assign in1 = din[0];
   assign in2 = din[1];
   assign in3 = din[2];
   assign in4 = din[3];

   always #5 clk = ~clk;

   mux41_rr_sched #(.WIDTH(4), .QUANTUM(1)) dut_q1 (
      .clk(clk), .rst(rst), .req(req), .in1(in1), .in2(in2), .in3(in3), .in4(in4),
      .gnt(gnt1), .select(sel1), .out(out1), .out_valid(ov1), .out_ready(out_ready),
      .state_dbg(st1), .cnt_dbg(cnt1)
   );

   mux41_rr_sched #(.WIDTH(4), .QUANTUM(4)) dut_q4 (
      .clk(clk), .rst(rst), .req(req), .in1(in1), .in2(in2), .in3(in3), .in4(in4),
      .gnt(gnt4), .select(sel4), .out(out4), .out_valid(ov4), .out_ready(out_ready),
      .state_dbg(st4), .cnt_dbg(cnt4)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_data();
      din[0] = 4'h3;
      din[1] = 4'h6;
      din[2] = 4'h9;
      din[3] = 4'hC;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      req       = 4'b0000;
      out_ready = 1'b0;
      set_data();
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      req       = 4'b1111;
      out_ready = 1'b1;
      set_data();
      #1;
      checks++;
      if (gnt1 !== 4'b0000 || gnt4 !== 4'b0000) begin
         errors++;
         $display("FAIL reset_gnt got %b/%b exp 0000", gnt1, gnt4);
      end
      tick();
      checks++;
      if (out4 !== 4'h0 || ov4 !== 1'b0 || sel4 !== 2'b11 || st4 !== IDLE || cnt4 !== 4'd0) begin
         errors++;
         $display("FAIL reset_q4 got out=%h v=%b sel=%0d st=%0d cnt=%0d exp 0 0 3 0 0",
                  out4, ov4, sel4, st4, cnt4);
      end
      checks++;
      if (ov1 !== 1'b0 || sel1 !== 2'b11 || cnt1 !== 4'd0) begin
         errors++;
         $display("FAIL reset_q1 got v=%b sel=%0d cnt=%0d exp 0 3 0", ov1, sel1, cnt1);
      end
      rst = 1'b0;
   endtask

   task automatic test_rr_q1();
      logic [3:0] eg;
      logic [1:0] es;
      do_reset();
      req       = 4'b1111;
      out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         es = 2'(k % 4);
         eg = 4'b0001 << es;
         #1;
         checks++;
         if (gnt1 !== eg) begin
            errors++;
            $display("FAIL rr_q1_gnt k=%0d got %b exp %b", k, gnt1, eg);
         end
         tick();
         checks++;
         if (sel1 !== es || out1 !== din[es] || ov1 !== 1'b1) begin
            errors++;
            $display("FAIL rr_q1_out k=%0d got sel=%0d out=%h v=%b exp %0d %h 1",
                     k, sel1, out1, ov1, es, din[es]);
         end
      end
   endtask

   task automatic test_quantum();
      logic [3:0] eg;
      logic [3:0] ec;
      do_reset();
      req       = 4'b0011;
      out_ready = 1'b1;
      for (int k = 0; k < 12; k++) begin
         eg = ((k / 4) % 2 == 0) ? 4'b0001 : 4'b0010;
         ec = 4'((k % 4) + 1);
         #1;
         checks++;
         if (gnt4 !== eg) begin
            errors++;
            $display("FAIL quantum_gnt k=%0d got %b exp %b", k, gnt4, eg);
         end
         tick();
         checks++;
         if (cnt4 !== ec || st4 !== BUSY) begin
            errors++;
            $display("FAIL quantum_cnt k=%0d got cnt=%0d st=%0d exp %0d 1", k, cnt4, st4, ec);
         end
      end
   endtask

   task automatic test_lone();
      logic [3:0] ec;
      do_reset();
      req       = 4'b0100;
      out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         ec = 4'((k % 4) + 1);
         #1;
         checks++;
         if (gnt4 !== 4'b0100) begin
            errors++;
            $display("FAIL lone_gnt k=%0d got %b exp 0100", k, gnt4);
         end
         tick();
         checks++;
         if (cnt4 !== ec || ov4 !== 1'b1 || out4 !== 4'h9 || sel4 !== 2'd2) begin
            errors++;
            $display("FAIL lone_out k=%0d got cnt=%0d v=%b out=%h sel=%0d exp %0d 1 9 2",
                     k, cnt4, ov4, out4, sel4, ec);
         end
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      req       = 4'b1001;
      out_ready = 1'b1;
      #1;
      checks++;
      if (gnt4 !== 4'b0001) begin
         errors++;
         $display("FAIL bp_first_gnt got %b exp 0001", gnt4);
      end
      tick();
      din[0]    = 4'h5;
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++;
         if (gnt4 !== 4'b0000) begin
            errors++;
            $display("FAIL bp_stall_gnt k=%0d got %b exp 0000", k, gnt4);
         end
         tick();
         checks++;
         if (out4 !== 4'h3 || sel4 !== 2'd0 || ov4 !== 1'b1 || cnt4 !== 4'd1) begin
            errors++;
            $display("FAIL bp_stall_hold k=%0d got out=%h sel=%0d v=%b cnt=%0d exp 3 0 1 1",
                     k, out4, sel4, ov4, cnt4);
         end
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (gnt4 !== 4'b0001) begin
         errors++;
         $display("FAIL bp_refill_gnt got %b exp 0001", gnt4);
      end
      tick();
      checks++;
      if (out4 !== 4'h5 || ov4 !== 1'b1 || cnt4 !== 4'd2) begin
         errors++;
         $display("FAIL bp_refill_out got out=%h v=%b cnt=%0d exp 5 1 2", out4, ov4, cnt4);
      end
      set_data();
   endtask

   task automatic test_idle();
      do_reset();
      req       = 4'b0001;
      out_ready = 1'b1;
      tick();
      req = 4'b0000;
      #1;
      checks++;
      if (gnt4 !== 4'b0000) begin
         errors++;
         $display("FAIL idle_gnt got %b exp 0000", gnt4);
      end
      tick();
      checks++;
      if (ov4 !== 1'b0 || st4 !== IDLE || cnt4 !== 4'd0 || sel4 !== 2'd0 || out4 !== 4'h3) begin
         errors++;
         $display("FAIL idle_state got v=%b st=%0d cnt=%0d sel=%0d out=%h exp 0 0 0 0 3",
                  ov4, st4, cnt4, sel4, out4);
      end
      tick();
      req = 4'b0010;
      #1;
      checks++;
      if (gnt4 !== 4'b0010) begin
         errors++;
         $display("FAIL idle_regrant got %b exp 0010", gnt4);
      end
      tick();
      checks++;
      if (ov4 !== 1'b1 || out4 !== 4'h6 || sel4 !== 2'd1 || cnt4 !== 4'd1) begin
         errors++;
         $display("FAIL idle_regrant_out got v=%b out=%h sel=%0d cnt=%0d exp 1 6 1 1",
                  ov4, out4, sel4, cnt4);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      req       = 4'b0011;
      out_ready = 1'b1;
      tick();
      tick();
      rst = 1'b1;
      #1;
      checks++;
      if (gnt4 !== 4'b0000 || gnt1 !== 4'b0000) begin
         errors++;
         $display("FAIL midrst_gnt got %b/%b exp 0000", gnt4, gnt1);
      end
      tick();
      checks++;
      if (ov4 !== 1'b0 || out4 !== 4'h0 || sel4 !== 2'b11 || st4 !== IDLE || cnt4 !== 4'd0) begin
         errors++;
         $display("FAIL midrst_state got v=%b out=%h sel=%0d st=%0d cnt=%0d exp 0 0 3 0 0",
                  ov4, out4, sel4, st4, cnt4);
      end
      rst = 1'b0;
      req = 4'b0110;
      #1;
      checks++;
      if (gnt4 !== 4'b0010) begin
         errors++;
         $display("FAIL midrst_first_gnt got %b exp 0010", gnt4);
      end
      tick();
      checks++;
      if (out4 !== 4'h6 || sel4 !== 2'd1 || ov4 !== 1'b1) begin
         errors++;
         $display("FAIL midrst_first_out got out=%h sel=%0d v=%b exp 6 1 1", out4, sel4, ov4);
      end
   endtask

   initial begin
      test_reset();
      test_rr_q1();
      test_quantum();
      test_lone();
      test_backpressure();
      test_idle();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
